// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main sequencing FSM for a shared-datapath RV32I core. A single ALU, one
// unified memory port and the immediate extender are reused across
// instruction phases. This block drives every datapath mux select and write
// enable, and stalls on the memory-ready handshake.
//
// Supported: lw, sw, R-type (add/sub/and/or/slt), I-type ALU
// (addi/andi/ori/slti), beq, jal. Any other opcode parks the FSM in TRAP and
// sets the sticky illegal flag.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high
//   op          in   Instr[6:0]
//   funct3      in   Instr[14:12]
//   funct7b5    in   Instr[30]
//   Zero        in   ALU zero flag
//   mem_ready   in   memory completes the current access this cycle
//   PCWrite     out  PC register enable
//   AdrSrc      out  memory address: 0 = PC, 1 = ALU result register
//   MemWrite    out  memory write strobe
//   IRWrite     out  instruction register / OldPC enable
//   RegWrite    out  register file write
//   ResultSrc   out  00 ALUOut, 01 Data, 10 ALU result
//   ALUSrcA     out  00 PC, 01 OldPC, 10 rs1
//   ALUSrcB     out  00 rs2, 01 ImmExt, 10 constant 4
//   ALUControl  out  000 add, 001 sub, 010 and, 011 or, 101 slt
//   ImmSrc      out  00 I, 01 S, 10 B, 11 J
//   illegal     out  sticky: unsupported opcode seen
//   state       out  current FSM state, for debug
//
// State table
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   FETCH    0  | read instruction at PC, PC <= PC + 4 on mem_ready
//   DECODE   1  | read registers, precompute OldPC + imm (branch/jump target)
//   MEMADR   2  | address = rs1 + imm
//   MEMREAD  3  | load data from memory, wait for mem_ready
//   MEMWB    4  | write loaded data to rd
//   MEMWRITE 5  | store rs2 to memory, MemWrite held until mem_ready
//   EXECR    6  | ALU on rs1, rs2
//   EXECI    7  | ALU on rs1, imm
//   ALUWB    8  | write ALUOut to rd
//   BEQ      9  | compare rs1 - rs2, take target when Zero
//   JAL     10  | PC <= target, ALU computes OldPC + 4 for the link
//   TRAP    11  | unsupported opcode, hold until reset
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;

  logic [1:0] alu_op;
  logic       pc_write_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;

  // ---------------------------------------------------------------------------
  // State and sticky illegal flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      // op is still held in the IR here, so it steers load vs store.
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_d = S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      // Unused encodings restart instruction fetch.
      default:    state_d = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore outputs (plus the mem_ready/Zero qualified enables)
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = ALUOP_ADD;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        // PC + 4 is written back together with the instruction, and only on
        // the cycle the memory actually returns it.
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b00;
        alu_op       = ALUOP_SUB;
        pc_write_raw = Zero;
      end
      S_JAL: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        pc_write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU decoder
  // ---------------------------------------------------------------------------
  always_comb begin
    ALUControl = ALU_ADD;
    unique case (alu_op)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (funct3)
          // funct7b5 is part of the immediate for I-type, so only R-type
          // (op[5] set) may select sub.
          3'b000:  ALUControl = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Immediate format select, independent of state
  // ---------------------------------------------------------------------------
  always_comb begin
    ImmSrc = 2'b00;
    unique case (op)
      OP_LW, OP_I: ImmSrc = 2'b00;
      OP_SW:       ImmSrc = 2'b01;
      OP_BEQ:      ImmSrc = 2'b10;
      OP_JAL:      ImmSrc = 2'b11;
      default:     ImmSrc = 2'b00;
    endcase
  end

  // Reset is synchronous, so the state register still holds the aborted
  // instruction's state during the reset cycle; mask every write enable so no
  // architectural state changes while reset is asserted.
  assign PCWrite  = pc_write_raw  & ~reset;
  assign MemWrite = mem_write_raw & ~reset;
  assign IRWrite  = ir_write_raw  & ~reset;
  assign RegWrite = reg_write_raw & ~reset;

  assign illegal  = illegal_q;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // ctrl = {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,
  //         ALUSrcB,ALUControl,ImmSrc,illegal}
  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        mr;
    logic        chk;
    logic [3:0]  st;
    logic [18:0] ctrl;
  } vec_t;

  typedef struct {
    int          idx;
    logic        chk;
    logic [3:0]  st;
    logic [18:0] ctrl;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  function automatic vec_t mk(logic rst, logic [6:0] o, logic [2:0] f3, logic f7,
                              logic z, logic mr, logic chk, logic [3:0] st,
                              logic [18:0] ctrl);
    vec_t v;
    v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = mr;
    v.chk = chk; v.st = st; v.ctrl = ctrl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    reset = v.rst; op = v.op; funct3 = v.f3; funct7b5 = v.f7;
    Zero = v.z; mem_ready = v.mr;
    e.idx = vec_no; e.chk = v.chk; e.st = v.st; e.ctrl = v.ctrl;
    sb.push_back(e);
    vec_no++;
  endtask

  // Outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [18:0] got;
      e = sb.pop_front();
      got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ALUControl, ImmSrc, illegal};
      if (e.chk) begin
        checks++;
        if (state !== e.st) begin
          errors++;
          $display("FAIL state vec %0d got %0d exp %0d", e.idx, state, e.st);
        end
        checks++;
        if (got !== e.ctrl) begin
          errors++;
          $display("FAIL ctrl vec %0d state %0d got %b exp %b", e.idx, state, got, e.ctrl);
        end
      end
    end
  end

  // sw from FETCH with n stall cycles in MEMWRITE: MemWrite held n+1 cycles.
  task automatic run_sw(input int n);
    drive(mk(0, SW, 3'd2, 0, 0, 1, 1, 4'd0, 19'b1_0_0_1_0_10_00_10_000_01_0));
    drive(mk(0, SW, 3'd2, 0, 0, 1, 1, 4'd1, 19'b0_0_0_0_0_00_01_01_000_01_0));
    drive(mk(0, SW, 3'd2, 0, 0, 1, 1, 4'd2, 19'b0_0_0_0_0_00_10_01_000_01_0));
    for (int i = 0; i < n; i++)
      drive(mk(0, SW, 3'd2, 0, 0, 0, 1, 4'd5, 19'b0_1_1_0_0_00_00_00_000_01_0));
    drive(mk(0, SW, 3'd2, 0, 0, 1, 1, 4'd5, 19'b0_1_1_0_0_00_00_00_000_01_0));
  endtask

  // FETCH stalled n cycles, then jal: PCWrite/IRWrite pulse only on ready.
  task automatic run_jal_stalled(input int n);
    for (int i = 0; i < n; i++)
      drive(mk(0, JL, 3'd0, 0, 0, 0, 1, 4'd0, 19'b0_0_0_0_0_10_00_10_000_11_0));
    drive(mk(0, JL, 3'd0, 0, 0, 1, 1, 4'd0,  19'b1_0_0_1_0_10_00_10_000_11_0));
    drive(mk(0, JL, 3'd0, 0, 0, 0, 1, 4'd1,  19'b0_0_0_0_0_00_01_01_000_11_0));
    drive(mk(0, JL, 3'd0, 0, 0, 0, 1, 4'd10, 19'b1_0_0_0_0_00_01_10_000_11_0));
    drive(mk(0, JL, 3'd0, 0, 0, 0, 1, 4'd8,  19'b0_0_0_0_1_00_00_00_000_11_0));
  endtask

  initial begin
    reset = 1'b1; op = LW; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
    mem_ready = 1'b1;

    // reset; second reset cycle checks enables forced low in FETCH
    vecs.push_back(mk(1, LW, 3'd0, 0, 0, 1, 0, 4'd0, 19'b0));
    vecs.push_back(mk(1, LW, 3'd0, 0, 0, 1, 1, 4'd0, 19'b0_0_0_0_0_10_00_10_000_00_0));
    // lw with one FETCH stall and one MEMREAD stall
    vecs.push_back(mk(0, LW, 3'd2, 0, 0, 0, 1, 4'd0, 19'b0_0_0_0_0_10_00_10_000_00_0));
    vecs.push_back(mk(0, LW, 3'd2, 0, 0, 1, 1, 4'd0, 19'b1_0_0_1_0_10_00_10_000_00_0));
    vecs.push_back(mk(0, LW, 3'd2, 0, 0, 1, 1, 4'd1, 19'b0_0_0_0_0_00_01_01_000_00_0));
    vecs.push_back(mk(0, LW, 3'd2, 0, 0, 1, 1, 4'd2, 19'b0_0_0_0_0_00_10_01_000_00_0));
    vecs.push_back(mk(0, LW, 3'd2, 0, 0, 0, 1, 4'd3, 19'b0_1_0_0_0_00_00_00_000_00_0));
    vecs.push_back(mk(0, LW, 3'd2, 0, 0, 1, 1, 4'd3, 19'b0_1_0_0_0_00_00_00_000_00_0));
    vecs.push_back(mk(0, LW, 3'd2, 0, 0, 1, 1, 4'd4, 19'b0_0_0_0_1_01_00_00_000_00_0));
    // lw, no stalls: 0,1,2,3,4
    vecs.push_back(mk(0, LW, 3'd2, 0, 0, 1, 1, 4'd0, 19'b1_0_0_1_0_10_00_10_000_00_0));
    vecs.push_back(mk(0, LW, 3'd2, 0, 0, 1, 1, 4'd1, 19'b0_0_0_0_0_00_01_01_000_00_0));
    vecs.push_back(mk(0, LW, 3'd2, 0, 0, 1, 1, 4'd2, 19'b0_0_0_0_0_00_10_01_000_00_0));
    vecs.push_back(mk(0, LW, 3'd2, 0, 0, 1, 1, 4'd3, 19'b0_1_0_0_0_00_00_00_000_00_0));
    vecs.push_back(mk(0, LW, 3'd2, 0, 0, 1, 1, 4'd4, 19'b0_0_0_0_1_01_00_00_000_00_0));
    // sw, two stall cycles in MEMWRITE
    vecs.push_back(mk(0, SW, 3'd2, 0, 0, 1, 1, 4'd0, 19'b1_0_0_1_0_10_00_10_000_01_0));
    vecs.push_back(mk(0, SW, 3'd2, 0, 0, 1, 1, 4'd1, 19'b0_0_0_0_0_00_01_01_000_01_0));
    vecs.push_back(mk(0, SW, 3'd2, 0, 0, 1, 1, 4'd2, 19'b0_0_0_0_0_00_10_01_000_01_0));
    vecs.push_back(mk(0, SW, 3'd2, 0, 0, 0, 1, 4'd5, 19'b0_1_1_0_0_00_00_00_000_01_0));
    vecs.push_back(mk(0, SW, 3'd2, 0, 0, 0, 1, 4'd5, 19'b0_1_1_0_0_00_00_00_000_01_0));
    vecs.push_back(mk(0, SW, 3'd2, 0, 0, 1, 1, 4'd5, 19'b0_1_1_0_0_00_00_00_000_01_0));
    // R-type sub
    vecs.push_back(mk(0, RT, 3'd0, 1, 0, 1, 1, 4'd0, 19'b1_0_0_1_0_10_00_10_000_00_0));
    vecs.push_back(mk(0, RT, 3'd0, 1, 0, 1, 1, 4'd1, 19'b0_0_0_0_0_00_01_01_000_00_0));
    vecs.push_back(mk(0, RT, 3'd0, 1, 0, 1, 1, 4'd6, 19'b0_0_0_0_0_00_10_00_001_00_0));
    vecs.push_back(mk(0, RT, 3'd0, 1, 0, 1, 1, 4'd8, 19'b0_0_0_0_1_00_00_00_000_00_0));
    // R-type and
    vecs.push_back(mk(0, RT, 3'd7, 0, 0, 1, 1, 4'd0, 19'b1_0_0_1_0_10_00_10_000_00_0));
    vecs.push_back(mk(0, RT, 3'd7, 0, 0, 1, 1, 4'd1, 19'b0_0_0_0_0_00_01_01_000_00_0));
    vecs.push_back(mk(0, RT, 3'd7, 0, 0, 1, 1, 4'd6, 19'b0_0_0_0_0_00_10_00_010_00_0));
    vecs.push_back(mk(0, RT, 3'd7, 0, 0, 1, 1, 4'd8, 19'b0_0_0_0_1_00_00_00_000_00_0));
    // addi with funct7b5=1 must stay add
    vecs.push_back(mk(0, IT, 3'd0, 1, 0, 1, 1, 4'd0, 19'b1_0_0_1_0_10_00_10_000_00_0));
    vecs.push_back(mk(0, IT, 3'd0, 1, 0, 1, 1, 4'd1, 19'b0_0_0_0_0_00_01_01_000_00_0));
    vecs.push_back(mk(0, IT, 3'd0, 1, 0, 1, 1, 4'd7, 19'b0_0_0_0_0_00_10_01_000_00_0));
    vecs.push_back(mk(0, IT, 3'd0, 1, 0, 1, 1, 4'd8, 19'b0_0_0_0_1_00_00_00_000_00_0));
    // slti
    vecs.push_back(mk(0, IT, 3'd2, 0, 0, 1, 1, 4'd0, 19'b1_0_0_1_0_10_00_10_000_00_0));
    vecs.push_back(mk(0, IT, 3'd2, 0, 0, 1, 1, 4'd1, 19'b0_0_0_0_0_00_01_01_000_00_0));
    vecs.push_back(mk(0, IT, 3'd2, 0, 0, 1, 1, 4'd7, 19'b0_0_0_0_0_00_10_01_101_00_0));
    vecs.push_back(mk(0, IT, 3'd2, 0, 0, 1, 1, 4'd8, 19'b0_0_0_0_1_00_00_00_000_00_0));
    // ori
    vecs.push_back(mk(0, IT, 3'd6, 0, 0, 1, 1, 4'd0, 19'b1_0_0_1_0_10_00_10_000_00_0));
    vecs.push_back(mk(0, IT, 3'd6, 0, 0, 1, 1, 4'd1, 19'b0_0_0_0_0_00_01_01_000_00_0));
    vecs.push_back(mk(0, IT, 3'd6, 0, 0, 1, 1, 4'd7, 19'b0_0_0_0_0_00_10_01_011_00_0));
    vecs.push_back(mk(0, IT, 3'd6, 0, 0, 1, 1, 4'd8, 19'b0_0_0_0_1_00_00_00_000_00_0));
    // beq taken
    vecs.push_back(mk(0, BQ, 3'd0, 0, 1, 1, 1, 4'd0, 19'b1_0_0_1_0_10_00_10_000_10_0));
    vecs.push_back(mk(0, BQ, 3'd0, 0, 1, 1, 1, 4'd1, 19'b0_0_0_0_0_00_01_01_000_10_0));
    vecs.push_back(mk(0, BQ, 3'd0, 0, 1, 1, 1, 4'd9, 19'b1_0_0_0_0_00_10_00_001_10_0));
    // beq not taken
    vecs.push_back(mk(0, BQ, 3'd0, 0, 0, 1, 1, 4'd0, 19'b1_0_0_1_0_10_00_10_000_10_0));
    vecs.push_back(mk(0, BQ, 3'd0, 0, 0, 1, 1, 4'd1, 19'b0_0_0_0_0_00_01_01_000_10_0));
    vecs.push_back(mk(0, BQ, 3'd0, 0, 0, 1, 1, 4'd9, 19'b0_0_0_0_0_00_10_00_001_10_0));
    // jal
    vecs.push_back(mk(0, JL, 3'd0, 0, 0, 1, 1, 4'd0,  19'b1_0_0_1_0_10_00_10_000_11_0));
    vecs.push_back(mk(0, JL, 3'd0, 0, 0, 1, 1, 4'd1,  19'b0_0_0_0_0_00_01_01_000_11_0));
    vecs.push_back(mk(0, JL, 3'd0, 0, 0, 1, 1, 4'd10, 19'b1_0_0_0_0_00_01_10_000_11_0));
    vecs.push_back(mk(0, JL, 3'd0, 0, 0, 1, 1, 4'd8,  19'b0_0_0_0_1_00_00_00_000_11_0));
    // lw aborted by reset in MEMREAD, reset held one more cycle in FETCH
    vecs.push_back(mk(0, LW, 3'd2, 0, 0, 1, 1, 4'd0, 19'b1_0_0_1_0_10_00_10_000_00_0));
    vecs.push_back(mk(0, LW, 3'd2, 0, 0, 1, 1, 4'd1, 19'b0_0_0_0_0_00_01_01_000_00_0));
    vecs.push_back(mk(0, LW, 3'd2, 0, 0, 1, 1, 4'd2, 19'b0_0_0_0_0_00_10_01_000_00_0));
    vecs.push_back(mk(1, LW, 3'd2, 0, 0, 1, 1, 4'd3, 19'b0_1_0_0_0_00_00_00_000_00_0));
    vecs.push_back(mk(1, LW, 3'd2, 0, 0, 1, 1, 4'd0, 19'b0_0_0_0_0_10_00_10_000_00_0));
    // sw aborted by reset in MEMWRITE: MemWrite forced low
    vecs.push_back(mk(0, SW, 3'd2, 0, 0, 1, 1, 4'd0, 19'b1_0_0_1_0_10_00_10_000_01_0));
    vecs.push_back(mk(0, SW, 3'd2, 0, 0, 1, 1, 4'd1, 19'b0_0_0_0_0_00_01_01_000_01_0));
    vecs.push_back(mk(0, SW, 3'd2, 0, 0, 1, 1, 4'd2, 19'b0_0_0_0_0_00_10_01_000_01_0));
    vecs.push_back(mk(1, SW, 3'd2, 0, 0, 0, 1, 4'd5, 19'b0_1_0_0_0_00_00_00_000_01_0));
    // illegal opcode: trap, sticky, cleared only by reset
    vecs.push_back(mk(0, BAD, 3'd0, 0, 0, 1, 1, 4'd0,  19'b1_0_0_1_0_10_00_10_000_00_0));
    vecs.push_back(mk(0, BAD, 3'd0, 0, 0, 1, 1, 4'd1,  19'b0_0_0_0_0_00_01_01_000_00_0));
    vecs.push_back(mk(0, BAD, 3'd0, 0, 0, 1, 1, 4'd11, 19'b0_0_0_0_0_00_00_00_000_00_1));
    vecs.push_back(mk(0, LW,  3'd0, 0, 1, 1, 1, 4'd11, 19'b0_0_0_0_0_00_00_00_000_00_1));
    vecs.push_back(mk(0, BAD, 3'd0, 0, 0, 0, 1, 4'd11, 19'b0_0_0_0_0_00_00_00_000_00_1));
    vecs.push_back(mk(1, BAD, 3'd0, 0, 0, 1, 1, 4'd11, 19'b0_0_0_0_0_00_00_00_000_00_1));
    vecs.push_back(mk(0, BAD, 3'd0, 0, 0, 0, 1, 4'd0,  19'b0_0_0_0_0_10_00_10_000_00_0));

    foreach (vecs[i]) drive(vecs[i]);

    // Hand-written multi-cycle corners with random stall lengths.
    run_sw($urandom_range(1, 6));
    run_jal_stalled($urandom_range(1, 5));
    run_sw($urandom_range(3, 8));
    drive(mk(0, LW, 3'd0, 0, 0, 0, 1, 4'd0, 19'b0_0_0_0_0_10_00_10_000_00_0));

    begin
      int waited = 0;
      while (sb.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      if (sb.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain pending %0d exp 0", sb.size());
      end
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
